// File: rtl/tape_pkg.sv
// -----------------------------------------------------------------------------
// tape_pkg
//   Shared types and constants for the tape receive path.
//   - tape_dec_state_t : decoder FSM states
//   - period_class_t   : classification of a measured edge-to-edge period
//   - DEF_*            : default period thresholds, in clk_cpu cycles
//   - CNT_W            : width of the period counter
//   - classify()       : maps a period to GLITCH / BIT0 / BIT1 (timeouts are
//                        detected separately from the saturated counter)
// -----------------------------------------------------------------------------
package tape_pkg;

  localparam int CNT_W = 14;

  localparam int DEF_SHORT_MIN  = 2000;
  localparam int DEF_SHORT_MAX  = 4875;
  localparam int DEF_LONG_MAX   = 9000;
  localparam int DEF_LEADER_MIN = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEADER = 2'd1,
    DATA   = 2'd2
  } tape_dec_state_t;

  typedef enum logic [1:0] {
    GLITCH = 2'd0,
    BIT0   = 2'd1,
    BIT1   = 2'd2
  } period_class_t;

  // Anything above short_max is reported as BIT1; the caller gives the
  // timeout condition priority so over-long periods never reach this branch.
  function automatic period_class_t classify(
    input logic [CNT_W-1:0] period,
    input logic [CNT_W-1:0] short_min,
    input logic [CNT_W-1:0] short_max
  );
    if (period < short_min)       return GLITCH;
    else if (period <= short_max) return BIT0;
    else                          return BIT1;
  endfunction

endpackage

// File: rtl/tape_edge_cond.sv
// -----------------------------------------------------------------------------
// tape_edge_cond
//   Conditions the raw comparator tape signal and produces a one-cycle rise
//   strobe per rising edge.
//     2-flop synchroniser -> optional 3-sample majority filter -> edge detect
//   Latency tape_in rising -> rise: 3 cycles, or 5 with the filter.
//
//   Build option: `TAPE_DECODER_GLITCH_FILTER_EN enables the majority filter,
//   which rejects single-cycle spikes on the synchronised input.
//
// Ports
//   clk_cpu  in   CPU clock
//   rst_n    in   asynchronous active-low reset
//   tape_in  in   raw comparator output, asynchronous to clk_cpu
//   rise     out  one-cycle pulse per conditioned rising edge
// -----------------------------------------------------------------------------
module tape_edge_cond (
  input  logic clk_cpu,
  input  logic rst_n,
  input  logic tape_in,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic level;
  logic level_d;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= tape_in;
      sync2 <= sync1;
    end
  end

`ifdef TAPE_DECODER_GLITCH_FILTER_EN
  logic hist1;
  logic hist2;
  logic filt;

  // Majority of the current and two previous synchronised samples, registered.
  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      hist1 <= 1'b0;
      hist2 <= 1'b0;
      filt  <= 1'b0;
    end else begin
      hist1 <= sync2;
      hist2 <= hist1;
      filt  <= (sync2 & hist1) | (sync2 & hist2) | (hist1 & hist2);
    end
  end

  assign level = filt;
`else
  assign level = sync2;
`endif

  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      level_d <= 1'b0;
      rise    <= 1'b0;
    end else begin
      level_d <= level;
      rise    <= level & ~level_d;
    end
  end

endmodule

// File: rtl/tape_decoder.sv
// -----------------------------------------------------------------------------
// tape_decoder
//   Receive side of the tape path. Times the period between conditioned rising
//   edges of tape_in, classifies each period as glitch / bit 0 / bit 1, locks
//   onto a leader of bit-0 periods followed by a bit-1 sync, then assembles
//   LSB-first bytes and offers them on a valid/ready handshake.
//
//   Build option: `TAPE_DECODER_GLITCH_FILTER_EN (see tape_edge_cond) adds a
//   majority filter on the synchronised input.
//
// Parameters (periods in clk_cpu cycles)
//   SHORT_MIN   shortest period accepted as a bit
//   SHORT_MAX   longest period classified as bit 0
//   LONG_MAX    longest period classified as bit 1; LONG_MAX+1 is a timeout
//   LEADER_MIN  bit-0 periods required before sync is armed
//
// Ports
//   clk_cpu     in   CPU clock
//   rst_n       in   asynchronous active-low reset
//   tape_in     in   raw comparator output
//   byte_ready  in   consumer accepts byte_data when byte_valid & byte_ready
//   byte_data   out  received byte, stable while byte_valid is high
//   byte_valid  out  a byte is pending
//   carrier     out  high while in LEADER or DATA
//   overrun     out  sticky; a byte completed while one was still pending
//   frame_err   out  one-cycle pulse on a glitch period inside DATA
// -----------------------------------------------------------------------------
module tape_decoder
  import tape_pkg::*;
#(
  parameter int SHORT_MIN  = DEF_SHORT_MIN,
  parameter int SHORT_MAX  = DEF_SHORT_MAX,
  parameter int LONG_MAX   = DEF_LONG_MAX,
  parameter int LEADER_MIN = DEF_LEADER_MIN
) (
  input  logic       clk_cpu,
  input  logic       rst_n,
  input  logic       tape_in,
  input  logic       byte_ready,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       carrier,
  output logic       overrun,
  output logic       frame_err
);

  localparam int LDR_W = $clog2(LEADER_MIN + 1);

  localparam logic [CNT_W-1:0] SMIN_C    = CNT_W'(SHORT_MIN);
  localparam logic [CNT_W-1:0] SMAX_C    = CNT_W'(SHORT_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT_C = CNT_W'(LONG_MAX + 1);
  localparam logic [LDR_W-1:0] LDR_MIN_C = LDR_W'(LEADER_MIN);

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic rise;

  tape_edge_cond u_edge_cond (
    .clk_cpu (clk_cpu),
    .rst_n   (rst_n),
    .tape_in (tape_in),
    .rise    (rise)
  );

  // ---------------------------------------------------------------------------
  // Period counter: holds the number of cycles since the last rise, so its
  // value in a rise cycle is exactly the period that rise terminates.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (rise) begin
      count <= CNT_W'(1);
    end else if (count != CNT_SAT_C) begin
      count <= count + 1'b1;
    end
  end

  logic          timeout;
  period_class_t cls;

  assign timeout = (count == CNT_SAT_C);
  assign cls     = classify(count, SMIN_C, SMAX_C);

  // ---------------------------------------------------------------------------
  // Decoder state
  // ---------------------------------------------------------------------------
  tape_dec_state_t  state,      state_n;
  logic [LDR_W-1:0] leader_cnt, leader_cnt_n;
  logic [2:0]       bit_idx,    bit_idx_n;
  logic [7:0]       sr,         sr_n;
  logic [7:0]       byte_data_n;
  logic             byte_valid_n;
  logic             overrun_n;
  logic             frame_err_n;
  logic             carrier_n;
  logic             byte_done;

  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      leader_cnt <= '0;
      bit_idx    <= '0;
      sr         <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
      carrier    <= 1'b0;
    end else begin
      state      <= state_n;
      leader_cnt <= leader_cnt_n;
      bit_idx    <= bit_idx_n;
      sr         <= sr_n;
      byte_data  <= byte_data_n;
      byte_valid <= byte_valid_n;
      overrun    <= overrun_n;
      frame_err  <= frame_err_n;
      carrier    <= carrier_n;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned and no latch is inferred.
    state_n      = state;
    leader_cnt_n = leader_cnt;
    bit_idx_n    = bit_idx;
    sr_n         = sr;
    byte_data_n  = byte_data;
    byte_valid_n = byte_valid & ~byte_ready;
    overrun_n    = overrun;
    frame_err_n  = 1'b0;
    byte_done    = 1'b0;

    unique case (state)
      IDLE: begin
        // The timeout check keeps the first edge after silence (whose period
        // is the saturated count) from being taken as data.
        if (rise && !timeout && cls == BIT0) begin
          leader_cnt_n = LDR_W'(1);
          state_n      = LEADER;
        end
      end

      LEADER: begin
        if (timeout) begin
          state_n = IDLE;
        end else if (rise) begin
          unique case (cls)
            BIT0: begin
              if (leader_cnt != LDR_MIN_C) leader_cnt_n = leader_cnt + 1'b1;
            end
            BIT1: begin
              if (leader_cnt >= LDR_MIN_C) begin
                state_n   = DATA;
                bit_idx_n = '0;
              end else begin
                state_n = IDLE;
              end
            end
            default: state_n = IDLE;
          endcase
        end
      end

      DATA: begin
        if (timeout) begin
          // End of block: silent return, partial byte dropped.
          state_n   = IDLE;
          bit_idx_n = '0;
        end else if (rise) begin
          if (cls == GLITCH) begin
            frame_err_n = 1'b1;
            state_n     = IDLE;
            bit_idx_n   = '0;
          end else begin
            sr_n = {(cls == BIT1), sr[7:1]};
            if (bit_idx == 3'd7) begin
              byte_done = 1'b1;
              bit_idx_n = '0;
            end else begin
              bit_idx_n = bit_idx + 1'b1;
            end
          end
        end
      end

      default: state_n = IDLE;
    endcase

    // A handshake in the completion cycle frees the slot for the new byte.
    if (byte_done) begin
      if (!byte_valid || byte_ready) begin
        byte_data_n  = sr_n;
        byte_valid_n = 1'b1;
      end else begin
        overrun_n = 1'b1;
      end
    end

    carrier_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_tape_decoder.sv
// -----------------------------------------------------------------------------
// tb_tape_decoder
//   Self-checking bench for tape_decoder with scaled-down thresholds
//   (SHORT_MIN 20, SHORT_MAX 48, LONG_MAX 90, LEADER_MIN 16; nominal bit 0 is
//   32 cycles, bit 1 is 64). Expected bytes are queued when a frame is sent
//   and compared on each handshake.
// -----------------------------------------------------------------------------
module tb_tape_decoder;

  localparam int SMIN   = 20;
  localparam int SMAX   = 48;
  localparam int LMAX   = 90;
  localparam int LDRMIN = 16;
  localparam int P0     = 32;
  localparam int P1     = 64;

  logic       clk_cpu = 1'b0;
  logic       rst_n   = 1'b0;
  logic       tape_in = 1'b0;
  logic       byte_ready = 1'b0;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       carrier;
  logic       overrun;
  logic       frame_err;

  int checks      = 0;
  int failures    = 0;
  int bytes_seen  = 0;
  int ferr_cycles = 0;
  logic [7:0] sb[$];

  always #5 clk_cpu = ~clk_cpu;

  tape_decoder #(
    .SHORT_MIN  (SMIN),
    .SHORT_MAX  (SMAX),
    .LONG_MAX   (LMAX),
    .LEADER_MIN (LDRMIN)
  ) dut (
    .clk_cpu    (clk_cpu),
    .rst_n      (rst_n),
    .tape_in    (tape_in),
    .byte_ready (byte_ready),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .carrier    (carrier),
    .overrun    (overrun),
    .frame_err  (frame_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output monitor, sampling mid-cycle.
  always @(negedge clk_cpu) begin
    if (rst_n) begin
      if (frame_err) ferr_cycles++;
      if (byte_valid && byte_ready) begin
        bytes_seen++;
        if (sb.size() == 0) check("unexpected_byte", {24'd0, byte_data}, 32'hFFFF_FFFF);
        else                check("byte", {24'd0, byte_data}, {24'd0, sb.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk_cpu);
    #1;
  endtask

  task automatic send_period(input int n);
    tape_in = 1'b1;
    repeat (n / 2) tick();
    tape_in = 1'b0;
    repeat (n - n / 2) tick();
  endtask

  task automatic send_leader(input int n);
    for (int i = 0; i < n; i++) send_period(P0);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits, input int p_zero, input int p_one);
    for (int i = 0; i < nbits; i++) send_period(b[i] ? p_one : p_zero);
  endtask

  // Final edge terminating the last bit, then silence long enough to time out.
  task automatic end_frame();
    tape_in = 1'b1;
    repeat (4) tick();
    tape_in = 1'b0;
    repeat (110) tick();
  endtask

  task automatic full_frame(input logic [7:0] b, input int p_zero, input int p_one);
    sb.push_back(b);
    send_leader(20);
    send_period(P1);
    send_bits(b, 8, p_zero, p_one);
    end_frame();
  endtask

  initial begin
    int lat;
    int f0;
    int seen0;

    // ---------------- reset values ----------------
    #2;
    check("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
    check("rst_byte_data",  {24'd0, byte_data},  32'd0);
    check("rst_carrier",    {31'd0, carrier},    32'd0);
    check("rst_overrun",    {31'd0, overrun},    32'd0);
    check("rst_frame_err",  {31'd0, frame_err},  32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    byte_ready = 1'b1;
    repeat (5) tick();

    // ---------------- basic frame 0xA5 ----------------
    sb.push_back(8'hA5);
    send_leader(20);
    check("leader_carrier", {31'd0, carrier}, 32'd1);
    send_period(P1);
    send_bits(8'hA5, 8, P0, P1);
    tape_in = 1'b1;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 4) tape_in = 1'b0;
      if (lat == 0 && byte_valid) lat = i;
    end
    check("valid_latency", lat, 32'd4);
    repeat (81) tick();
    check("carrier_before_timeout", {31'd0, carrier}, 32'd1);
    repeat (4) tick();
    check("carrier_after_timeout", {31'd0, carrier}, 32'd0);
    check("a5_no_frame_err", ferr_cycles, 32'd0);
    check("a5_bytes", bytes_seen, 32'd1);
    check("a5_no_overrun", {31'd0, overrun}, 32'd0);
    repeat (20) tick();

    // ---------------- short leader ----------------
    seen0 = bytes_seen;
    send_leader(6);
    check("short_leader_carrier", {31'd0, carrier}, 32'd1);
    send_period(P1);
    tape_in = 1'b1;
    repeat (6) tick();
    check("short_sync_idle", {31'd0, carrier}, 32'd0);
    tape_in = 1'b0;
    repeat (110) tick();
    check("short_no_byte", bytes_seen, seen0);
    check("short_no_valid", {31'd0, byte_valid}, 32'd0);

    // ---------------- glitch mid-byte ----------------
    f0 = ferr_cycles;
    seen0 = bytes_seen;
    send_leader(20);
    send_period(P1);
    send_bits(8'h05, 3, P0, P1);
    send_period(SMIN - 1);
    tape_in = 1'b1;
    repeat (6) tick();
    tape_in = 1'b0;
    check("glitch_frame_err_1cyc", ferr_cycles - f0, 32'd1);
    check("glitch_idle", {31'd0, carrier}, 32'd0);
    check("glitch_no_valid", {31'd0, byte_valid}, 32'd0);
    repeat (110) tick();
    check("glitch_no_byte", bytes_seen, seen0);

    // ---------------- boundary periods ----------------
    full_frame(8'h5A, SMAX, SMAX + 1);
    full_frame(8'hC3, SMIN, LMAX);
    f0 = ferr_cycles;
    seen0 = bytes_seen;
    send_leader(20);
    send_period(P1);
    send_bits(8'h02, 3, P0, P1);
    check("pre_timeout_carrier", {31'd0, carrier}, 32'd1);
    send_period(LMAX + 1);
    tape_in = 1'b1;
    repeat (6) tick();
    tape_in = 1'b0;
    check("timeout_idle", {31'd0, carrier}, 32'd0);
    check("timeout_no_err", ferr_cycles - f0, 32'd0);
    repeat (110) tick();
    check("timeout_no_byte", bytes_seen, seen0);

    // ---------------- overrun ----------------
    byte_ready = 1'b0;
    sb.push_back(8'h3C);
    send_leader(20);
    send_period(P1);
    send_bits(8'h3C, 8, P0, P1);
    send_bits(8'hFF, 8, P0, P1);
    end_frame();
    check("ovr_valid", {31'd0, byte_valid}, 32'd1);
    check("ovr_data", {24'd0, byte_data}, 32'h3C);
    check("ovr_flag", {31'd0, overrun}, 32'd1);
    repeat (20) tick();
    byte_ready = 1'b1;
    repeat (3) tick();
    check("ovr_drained", {31'd0, byte_valid}, 32'd0);
    check("ovr_sticky", {31'd0, overrun}, 32'd1);

    // ---------------- reset mid-byte ----------------
    send_leader(20);
    send_period(P1);
    send_bits(8'h07, 3, P0, P1);
    tape_in = 1'b1;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_byte_data", {24'd0, byte_data}, 32'd0);
    check("mid_rst_valid",     {31'd0, byte_valid}, 32'd0);
    check("mid_rst_carrier",   {31'd0, carrier},    32'd0);
    check("mid_rst_overrun",   {31'd0, overrun},    32'd0);
    check("mid_rst_frame_err", {31'd0, frame_err},  32'd0);
    tape_in = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    full_frame(8'h69, P0, P1);
    check("post_rst_no_overrun", {31'd0, overrun}, 32'd0);

    // ---------------- wrap-up ----------------
    check("sb_empty", sb.size(), 32'd0);
    check("total_bytes", bytes_seen, 32'd5);
    check("total_frame_err", ferr_cycles, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
